// File: rtl/enc_dec_pipe.sv
// enc_dec_pipe: two-stage priority encode (fixed or round-robin) and one-hot decode
module enc_dec_pipe #(
  parameter int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [N-1:0] in,
  input  logic         mode,
  output logic         out_valid,
  output logic [W-1:0] index,
  output logic         found,
  output logic [N-1:0] out
);
  logic [W-1:0] ptr, index1, hi, lo, sel;
  logic [N-1:0] rot;
  logic         valid1, found1;
  always_comb begin
    hi = '0;
    lo = '0;
    rot = N'({in, in} >> ptr);
    for (int i = 0; i < N; i++) if (in[i]) hi = W'(i);
    for (int i = N - 1; i >= 0; i--) if (rot[i]) lo = W'(i);
    sel = ~|in ? '0 : mode ? lo + ptr : hi;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr       <= '0;
      valid1    <= 1'b0;
      index1    <= '0;
      found1    <= 1'b0;
      out_valid <= 1'b0;
      index     <= '0;
      found     <= 1'b0;
      out       <= '0;
    end else begin
      valid1    <= in_valid;
      out_valid <= valid1;
      if (in_valid) begin
        index1 <= sel;
        found1 <= |in;
        if (mode && |in) ptr <= sel + W'(1);
      end
      if (valid1) begin
        index <= index1;
        found <= found1;
        out   <= N'(found1) << index1;
      end
    end
  end
endmodule

// File: tb/tb_enc_dec_pipe.sv
// tb_enc_dec_pipe: directed checks of enc_dec_pipe at N = 8, 4 and 2
module tb_enc_dec_pipe;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       iv8 = 1'b0, md8 = 1'b0;
  logic [7:0] in8 = '0;
  logic       ov8, fd8;
  logic [2:0] ix8;
  logic [7:0] o8;
  logic       iv4 = 1'b0, md4 = 1'b0;
  logic [3:0] in4 = '0;
  logic       ov4, fd4;
  logic [1:0] ix4;
  logic [3:0] o4;
  logic       iv2 = 1'b0, md2 = 1'b0;
  logic [1:0] in2 = '0;
  logic       ov2, fd2;
  logic       ix2;
  logic [1:0] o2;
  int n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  enc_dec_pipe #(.N(8)) dut8 (.clk(clk), .rst_n(rst_n), .in_valid(iv8), .in(in8), .mode(md8),
    .out_valid(ov8), .index(ix8), .found(fd8), .out(o8));
  enc_dec_pipe #(.N(4)) dut4 (.clk(clk), .rst_n(rst_n), .in_valid(iv4), .in(in4), .mode(md4),
    .out_valid(ov4), .index(ix4), .found(fd4), .out(o4));
  enc_dec_pipe #(.N(2)) dut2 (.clk(clk), .rst_n(rst_n), .in_valid(iv2), .in(in2), .mode(md2),
    .out_valid(ov2), .index(ix2), .found(fd2), .out(o2));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drv(input logic v, input logic [7:0] d, input logic m);
    iv8 = v;
    in8 = d;
    md8 = m;
    @(negedge clk);
  endtask

  task automatic rst(input int cycles);
    rst_n = 1'b0;
    iv8 = 1'b0;
    repeat (cycles) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic chk8(input string tag, input logic v, input logic [2:0] ix, input logic f, input logic [7:0] o);
    chk({tag, ".ov"}, 32'(ov8), 32'(v));
    chk({tag, ".ix"}, 32'(ix8), 32'(ix));
    chk({tag, ".fd"}, 32'(fd8), 32'(f));
    chk({tag, ".out"}, 32'(o8), 32'(o));
  endtask

  initial begin
    logic [2:0] ww [3];
    ww[0] = 3'd0;
    ww[1] = 3'd7;
    ww[2] = 3'd0;
    @(negedge clk);
    rst(2);
    chk8("reset", 1'b0, 3'd0, 1'b0, 8'h00);
    chk("reset4.ov", 32'(ov4), 32'd0);
    chk("reset2.ov", 32'(ov2), 32'd0);
    // fixed priority: highest set bit wins
    drv(1'b1, 8'h24, 1'b0);
    drv(1'b0, 8'h00, 1'b0);
    chk8("fixed", 1'b1, 3'd5, 1'b1, 8'h20);
    // round-robin over a full vector; pointer must still be 0 after the fixed vector
    for (int i = 0; i < 11; i++) begin
      if (i < 9) drv(1'b1, 8'hFF, 1'b1);
      else drv(1'b0, 8'h00, 1'b1);
      if (i >= 1 && i <= 9) chk8($sformatf("rr%0d", i - 1), 1'b1, 3'((i - 1) % 8), 1'b1, 8'(1 << ((i - 1) % 8)));
      if (i == 10) chk("rr.bubble", 32'(ov8), 32'd0);
    end
    rst(1);
    for (int i = 0; i < 4; i++) begin
      if (i < 3) drv(1'b1, 8'h81, 1'b1);
      else drv(1'b0, 8'h00, 1'b1);
      if (i >= 1) chk8($sformatf("wrap%0d", i - 1), 1'b1, ww[i - 1], 1'b1, 8'(1 << ww[i - 1]));
    end
    drv(1'b0, 8'h00, 1'b0);
    // empty vector, bubble, then a real vector
    drv(1'b1, 8'h00, 1'b0);
    drv(1'b0, 8'h00, 1'b0);
    chk8("empty", 1'b1, 3'd0, 1'b0, 8'h00);
    drv(1'b1, 8'h10, 1'b0);
    chk8("bubble", 1'b0, 3'd0, 1'b0, 8'h00);
    drv(1'b0, 8'h00, 1'b0);
    chk8("after", 1'b1, 3'd4, 1'b1, 8'h10);
    drv(1'b0, 8'h00, 1'b0);
    chk("idle.ov", 32'(ov8), 32'd0);
    // reset while a vector is in flight: it must vanish and the pointer return to 0
    drv(1'b1, 8'h0C, 1'b1);
    rst(1);
    chk8("midrst", 1'b0, 3'd0, 1'b0, 8'h00);
    drv(1'b0, 8'h00, 1'b1);
    chk("midrst.ov2", 32'(ov8), 32'd0);
    drv(1'b1, 8'h0C, 1'b1);
    drv(1'b0, 8'h00, 1'b1);
    chk8("postrst", 1'b1, 3'd2, 1'b1, 8'h04);
    // narrower instances
    iv4 = 1'b1;
    in4 = 4'b0011;
    md4 = 1'b0;
    @(negedge clk);
    iv4 = 1'b0;
    @(negedge clk);
    chk("n4.ov", 32'(ov4), 32'd1);
    chk("n4.ix", 32'(ix4), 32'd1);
    chk("n4.out", 32'(o4), 32'h2);
    iv2 = 1'b1;
    in2 = 2'b11;
    md2 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) iv2 = 1'b0;
      @(negedge clk);
      if (i >= 1) begin
        chk($sformatf("n2.ov%0d", i - 1), 32'(ov2), 32'd1);
        chk($sformatf("n2.ix%0d", i - 1), 32'(ix2), 32'((i - 1) % 2));
        chk($sformatf("n2.out%0d", i - 1), 32'(o2), 32'(1 << ((i - 1) % 2)));
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
